// File: rtl/wptr_full_gen.sv
// Write-side pointer and full-flag generator for the async FIFO.
// It holds the binary write pointer and drives the memory write port.
// It publishes a registered Gray write pointer for the read-domain synchronizer.
// Occupancy flags are computed against the read pointer already synced into clk.
module wptr_full_gen #(
    parameter int ADDR_LEN     = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                winc,
    input  logic [ADDR_LEN:0]   rptr_sync,
    input  logic                ovf_clr,
    output logic [ADDR_LEN-1:0] waddr,
    output logic                wen,
    output logic [ADDR_LEN:0]   wptr,
    output logic                full,
    output logic                almost_full,
    output logic [ADDR_LEN:0]   wcount,
    output logic                overflow
);

    localparam int PW = ADDR_LEN + 1;
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] wcount_next;

    // A write is accepted only when there is room; full blocks it entirely.
    assign wen        = winc & ~full;
    assign waddr      = wbin[ADDR_LEN-1:0];
    assign wbin_next  = wbin + {{(PW-1){1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Full means the write pointer is one lap ahead of the read pointer.
    // In Gray code that inverts the top two bits of the read pointer.
    assign full_cmp   = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};

    // Convert the synced read pointer from Gray to binary, MSB first.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        rbin_s = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            acc       = acc ^ rptr_sync[i];
            rbin_s[i] = acc;
        end
    end

    // Fill level uses the next write pointer so the flags track writes with zero lag.
    assign wcount_next = wbin_next - rbin_s;

    // Advance the pointers and register the flags for the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= (wgray_next == full_cmp);
            almost_full <= (wcount_next >= AF_TH);
            wcount      <= wcount_next;
        end
    end

    // Sticky overflow: a write attempt while full sets it, and set wins over clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            overflow <= 1'b0;
        else if (winc & full)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule
